// File: rtl/ro_count_comparator.sv
// ro_count_comparator: registered comparator for pairs of ring-oscillator counts.
// Each accepted pair produces a response bit, a tie/unstable flag and |count1-count2|.
// Successive response bits are packed LSB-first into a RESP_BITS-wide response word.
//
// Optional feature macro: COMPARATOR_MARGIN_EN
//   defined     -> a pair is a tie when abs_diff <= TIE_MARGIN
//   not defined -> a pair is a tie only when abs_diff == 0 (TIE_MARGIN unused)
//
// Handshake: in_valid qualifies count1/count2 in the cycle it is high. There is no
// backpressure, so every cycle with in_valid high (and clr low) is accepted.
// out_valid and word_valid are one-cycle pulses, with no ready. A consumer that
// misses a pulse loses that result. clr has priority over in_valid.
module ro_count_comparator #(
    parameter int WIDTH      = 32,
    parameter int TIE_MARGIN = 4,
    parameter int RESP_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     count1,
    input  logic [WIDTH-1:0]     count2,
    output logic                 out_valid,
    output logic                 response,
    output logic                 unstable,
    output logic [WIDTH-1:0]     abs_diff,
    output logic [RESP_BITS-1:0] resp_word,
    output logic                 word_valid
);

    localparam int CNT_W = $clog2(RESP_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(RESP_BITS - 1);

    logic [WIDTH:0]       diff_ext;
    logic                 c1_lt_c2;
    logic [WIDTH-1:0]     abs_val;
    logic                 tie;
    logic                 resp_bit;
    logic [CNT_W-1:0]     bit_cnt;
    logic [RESP_BITS-1:0] partial;
    logic [RESP_BITS-1:0] partial_next;

    // Compare the counts. The sign of the WIDTH+1 bit difference gives count1 < count2.
    always_comb begin
        diff_ext = {1'b0, count1} - {1'b0, count2};
        c1_lt_c2 = diff_ext[WIDTH];
        abs_val  = c1_lt_c2 ? (count2 - count1) : (count1 - count2);
`ifdef COMPARATOR_MARGIN_EN
        tie      = (abs_val <= WIDTH'(TIE_MARGIN));
`else
        tie      = (abs_val == '0);
`endif
        resp_bit = tie ? 1'b1 : c1_lt_c2;
    end

    // Write the new response bit into the partial word at the current bit position.
    always_comb begin
        partial_next          = partial;
        partial_next[bit_cnt] = resp_bit;
    end

    // Register the per-pair results and assemble the response word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            response   <= 1'b0;
            unstable   <= 1'b0;
            abs_diff   <= '0;
            resp_word  <= '0;
            word_valid <= 1'b0;
            bit_cnt    <= '0;
            partial    <= '0;
        end else begin
            out_valid  <= 1'b0;
            word_valid <= 1'b0;
            if (clr) begin
                // A pair that arrives together with clr is dropped. resp_word keeps its value.
                bit_cnt <= '0;
                partial <= '0;
            end else if (in_valid) begin
                out_valid <= 1'b1;
                response  <= resp_bit;
                unstable  <= tie;
                abs_diff  <= abs_val;
                if (bit_cnt == LAST_BIT) begin
                    resp_word  <= partial_next;
                    word_valid <= 1'b1;
                    bit_cnt    <= '0;
                    partial    <= '0;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    partial <= partial_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_ro_count_comparator.sv
// tb_ro_count_comparator: directed vectors with hand-computed expectations.
// The driver pushes one expected record per accepted pair. The monitor pops a record
// on every out_valid pulse and compares it against the DUT outputs.
module tb_ro_count_comparator;

    localparam int WIDTH      = 32;
    localparam int TIE_MARGIN = 4;
    localparam int RESP_BITS  = 8;
    // Expected record layout: {response, unstable, abs_diff, word_valid, resp_word}
    localparam int EW = 1 + 1 + WIDTH + 1 + RESP_BITS;

    logic                 clk;
    logic                 rst_n;
    logic                 clr;
    logic                 in_valid;
    logic [WIDTH-1:0]     count1;
    logic [WIDTH-1:0]     count2;
    logic                 out_valid;
    logic                 response;
    logic                 unstable;
    logic [WIDTH-1:0]     abs_diff;
    logic [RESP_BITS-1:0] resp_word;
    logic                 word_valid;

    logic [EW-1:0] exp_q[$];
    int n_vec;
    int n_err;

    // Model of the word assembly only. The per-pair values come from the vector tables.
    int                   m_cnt;
    logic [RESP_BITS-1:0] m_word;
    logic [RESP_BITS-1:0] m_last;

    ro_count_comparator #(
        .WIDTH(WIDTH),
        .TIE_MARGIN(TIE_MARGIN),
        .RESP_BITS(RESP_BITS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clr(clr),
        .in_valid(in_valid),
        .count1(count1),
        .count2(count2),
        .out_valid(out_valid),
        .response(response),
        .unstable(unstable),
        .abs_diff(abs_diff),
        .resp_word(resp_word),
        .word_valid(word_valid)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Driver: apply one pair for one clock and push its expected record.
    task automatic send(input logic [WIDTH-1:0] c1, input logic [WIDTH-1:0] c2,
                        input logic er, input logic eu, input logic [WIDTH-1:0] ea);
        logic ewv;
        count1   = c1;
        count2   = c2;
        in_valid = 1'b1;
        m_word[m_cnt] = er;
        if (m_cnt == RESP_BITS - 1) begin
            ewv    = 1'b1;
            m_last = m_word;
            m_word = '0;
            m_cnt  = 0;
        end else begin
            ewv   = 1'b0;
            m_cnt = m_cnt + 1;
        end
        exp_q.push_back({er, eu, ea, ewv, m_last});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_lt();  // (20,80): count1 < count2, so the response is 1
        send(32'd20, 32'd80, 1'b1, 1'b0, 32'd60);
    endtask

    task automatic send_gt();  // (100,50): count1 > count2, so the response is 0
        send(32'd100, 32'd50, 1'b0, 1'b0, 32'd50);
    endtask

    // Monitor: compare on every out_valid pulse, sampled on the falling edge.
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            if (!out_valid && word_valid)
                check("word_valid_without_out_valid", 64'(word_valid), 64'(0));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 64'(out_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("response",   64'(response),   64'(e[EW-1]));
                    check("unstable",   64'(unstable),   64'(e[EW-2]));
                    check("abs_diff",   64'(abs_diff),   64'(e[EW-3 -: WIDTH]));
                    check("word_valid", 64'(word_valid), 64'(e[RESP_BITS]));
                    check("resp_word",  64'(resp_word),  64'(e[RESP_BITS-1:0]));
                end
            end
        end
    end

    // Stimulus sequence.
    initial begin
        n_vec    = 0;
        n_err    = 0;
        m_cnt    = 0;
        m_word   = '0;
        m_last   = '0;
        rst_n    = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        count1   = '0;
        count2   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid",  64'(out_valid),  64'(0));
        check("rst_response",   64'(response),   64'(0));
        check("rst_unstable",   64'(unstable),   64'(0));
        check("rst_abs_diff",   64'(abs_diff),   64'(0));
        check("rst_resp_word",  64'(resp_word),  64'(0));
        check("rst_word_valid", 64'(word_valid), 64'(0));
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed pairs, sent back-to-back. These eight pairs complete one word.
        send(32'd100, 32'd50, 1'b0, 1'b0, 32'd50);
        send(32'd20,  32'd80, 1'b1, 1'b0, 32'd60);
`ifdef COMPARATOR_MARGIN_EN
        send(32'd55,  32'd52, 1'b1, 1'b1, 32'd3);
        send(32'd52,  32'd56, 1'b1, 1'b1, 32'd4);   // difference of exactly TIE_MARGIN is a tie
`else
        send(32'd55,  32'd52, 1'b0, 1'b0, 32'd3);
        send(32'd52,  32'd56, 1'b1, 1'b0, 32'd4);
`endif
        send(32'd7,   32'd7,  1'b1, 1'b1, 32'd0);
        send(32'd60,  32'd55, 1'b0, 1'b0, 32'd5);
        send(32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF);
        send(32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFF);

        // Idle cycle: out_valid drops and the per-pair outputs hold their values.
        @(posedge clk);
        #1;
        check("idle_out_valid", 64'(out_valid), 64'(0));
        check("idle_response",  64'(response),  64'(0));
        check("idle_abs_diff",  64'(abs_diff),  64'(32'hFFFF_FFFF));
        check("idle_resp_word", 64'(resp_word), 64'(m_last));

        // Alternating pairs build the word 8'b01010101.
        for (int i = 0; i < 4; i++) begin
            send_lt();
            send_gt();
        end
        check("alt_word_model", 64'(m_last), 64'(8'h55));

        // Three pairs, then clr arrives together with in_valid. clr wins.
        send_lt();
        send_lt();
        send_lt();
        count1   = 32'd100;
        count2   = 32'd50;
        clr      = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        m_cnt    = 0;
        m_word   = '0;
        check("clr_out_valid",  64'(out_valid),  64'(0));
        check("clr_response",   64'(response),   64'(1));
        check("clr_resp_word",  64'(resp_word),  64'(8'h55));
        check("clr_word_valid", 64'(word_valid), 64'(0));
        // With no residue, eight (100,50) pairs build the word 8'h00.
        for (int i = 0; i < 8; i++) send_gt();

        // Reset in the middle of a word clears the outputs at once.
        send_lt();
        send_lt();
        send_lt();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_response",  64'(response),  64'(0));
        check("midrst_abs_diff",  64'(abs_diff),  64'(0));
        check("midrst_resp_word", 64'(resp_word), 64'(0));
        m_cnt  = 0;
        m_word = '0;
        m_last = '0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Eight (20,80) pairs after reset build the word 8'hFF.
        for (int i = 0; i < 8; i++) send_lt();
        check("final_word_model", 64'(m_last), 64'(8'hFF));

        // Wait a bounded number of cycles for the scoreboard to drain.
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
